// File: rtl/tmr_irq_ctrl_pkg.sv
// Shared timer register-map definitions: timer core addresses, interrupt controller
// addresses and bit positions, and the APB handshake state encoding.
package tmr_irq_ctrl_pkg;

    // Timer core registers, decoded by the timer block itself.
    localparam int unsigned TDR_ADDR  = 'h00;
    localparam int unsigned TCR_ADDR  = 'h01;
    localparam int unsigned TSR_ADDR  = 'h02;
    localparam int unsigned TCNT_ADDR = 'h03;

    // Interrupt controller registers.
    localparam int unsigned IER_ADDR  = 'h10;
    localparam int unsigned ISR_ADDR  = 'h11;
    localparam int unsigned ICNT_ADDR = 'h12;
    localparam int unsigned ITHR_ADDR = 'h13;

    localparam int unsigned OVF_BIT   = 0;
    localparam int unsigned UDF_BIT   = 1;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned FIELD_W   = 4;
    localparam int unsigned ICNT_MAX  = 15;
    localparam int unsigned ITHR_RST  = 1;

    typedef enum logic [1:0] {
        APB_IDLE  = 2'd0,
        APB_WAIT  = 2'd1,
        APB_READY = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_IER  = 3'd1,
        SEL_ISR  = 3'd2,
        SEL_ICNT = 3'd3,
        SEL_ITHR = 3'd4
    } reg_sel_e;

endpackage

// File: rtl/tmr_irq_ctrl_event_counter.sv
// Saturating interrupt event counter (ICNT) with optional threshold compare.
// Threshold logic only exists when TMR_IRQ_COALESCE_EN is defined.
module irq_event_counter
    import tmr_irq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ovf_evt,
    input  logic               udf_evt,
    input  logic               clr,
`ifdef TMR_IRQ_COALESCE_EN
    input  logic [FIELD_W-1:0] thr,
    output logic               thr_met_c,
`endif
    output logic [FIELD_W-1:0] icnt
);

    logic [FIELD_W:0] sum_c;

    // A clear restarts from zero but still counts events of the same cycle.
    assign sum_c = (clr ? (FIELD_W+1)'(0) : {1'b0, icnt})
                 + (FIELD_W+1)'(ovf_evt) + (FIELD_W+1)'(udf_evt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= '0;
        end else if (sum_c > (FIELD_W+1)'(ICNT_MAX)) begin
            icnt <= FIELD_W'(ICNT_MAX);
        end else begin
            icnt <= sum_c[FIELD_W-1:0];
        end
    end

`ifdef TMR_IRQ_COALESCE_EN
    logic [FIELD_W-1:0] thr_eff_c;

    // A zero threshold behaves like a threshold of one.
    assign thr_eff_c = (thr == '0) ? FIELD_W'(1) : thr;
    assign thr_met_c = (icnt >= thr_eff_c);
`endif

endmodule

// File: rtl/tmr_irq_ctrl.sv
// Timer interrupt controller: APB slave with IER/ISR/ICNT (and ITHR when
// TMR_IRQ_COALESCE_EN is defined) plus a registered level interrupt request.
module tmr_irq_ctrl
    import tmr_irq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  Set_OVF_pulse,
    input  logic                  Set_UDF_pulse,
    output logic                  TMR_IRQ
);

    apb_state_e         state;
    reg_sel_e           sel_c;
    reg_sel_e           req_sel;
    logic               req_write;
    logic [FIELD_W-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic               err_c;

    logic [SRC_W-1:0]   ier;
    logic [SRC_W-1:0]   isr;
    logic [FIELD_W-1:0] icnt;
    logic [SRC_W-1:0]   evt_c;
    logic [SRC_W-1:0]   evt_en_c;
    logic [SRC_W-1:0]   isr_clr_c;
    logic               commit_c;
    logic               wr_ier_c;
    logic               wr_isr_c;
    logic               icnt_clr_c;
    logic               irq_cond_c;
    logic               unused_ok;

`ifdef TMR_IRQ_COALESCE_EN
    logic [FIELD_W-1:0] ithr;
    logic               wr_ithr_c;
    logic               thr_met_c;
`endif

    // Address decode and read mux, evaluated on the live bus during WAIT.
    always_comb begin
        sel_c     = SEL_NONE;
        rd_data_c = '0;
        if (PADDR == ADDR_WIDTH'(IER_ADDR)) begin
            sel_c     = SEL_IER;
            rd_data_c = DATA_WIDTH'(ier);
        end else if (PADDR == ADDR_WIDTH'(ISR_ADDR)) begin
            sel_c     = SEL_ISR;
            rd_data_c = DATA_WIDTH'(isr);
        end else if (PADDR == ADDR_WIDTH'(ICNT_ADDR)) begin
            sel_c     = SEL_ICNT;
            rd_data_c = DATA_WIDTH'(icnt);
`ifdef TMR_IRQ_COALESCE_EN
        end else if (PADDR == ADDR_WIDTH'(ITHR_ADDR)) begin
            sel_c     = SEL_ITHR;
            rd_data_c = DATA_WIDTH'(ithr);
`endif
        end
    end

    assign err_c = (sel_c == SEL_NONE) || (PWRITE && (sel_c == SEL_ICNT));

    // APB handshake: IDLE -> WAIT -> READY -> IDLE, outputs registered for READY.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state     <= APB_IDLE;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            req_sel   <= SEL_NONE;
            req_write <= 1'b0;
            req_wdata <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    if (PSEL && PENABLE) begin
                        state <= APB_WAIT;
                    end
                end
                APB_WAIT: begin
                    if (!PSEL) begin
                        state <= APB_IDLE;
                    end else begin
                        state     <= APB_READY;
                        PREADY    <= 1'b1;
                        PSLVERR   <= err_c;
                        PRDATA    <= (err_c || PWRITE) ? '0 : rd_data_c;
                        req_sel   <= sel_c;
                        req_write <= PWRITE && !err_c;
                        req_wdata <= PWDATA[FIELD_W-1:0];
                    end
                end
                APB_READY: begin
                    state     <= APB_IDLE;
                    PREADY    <= 1'b0;
                    PSLVERR   <= 1'b0;
                    PRDATA    <= '0;
                    req_write <= 1'b0;
                end
                default: begin
                    state <= APB_IDLE;
                end
            endcase
        end
    end

    assign commit_c   = (state == APB_READY) && req_write;
    assign wr_ier_c   = commit_c && (req_sel == SEL_IER);
    assign wr_isr_c   = commit_c && (req_sel == SEL_ISR);
    assign isr_clr_c  = wr_isr_c ? req_wdata[SRC_W-1:0] : '0;
    assign icnt_clr_c = |isr_clr_c;

    always_comb begin
        evt_c          = '0;
        evt_c[OVF_BIT] = Set_OVF_pulse;
        evt_c[UDF_BIT] = Set_UDF_pulse;
    end

    assign evt_en_c = evt_c & ier;

`ifdef TMR_IRQ_COALESCE_EN
    assign wr_ithr_c  = commit_c && (req_sel == SEL_ITHR);
    assign irq_cond_c = (|(isr & ier)) && thr_met_c;
    assign unused_ok  = &{1'b0, PWDATA[DATA_WIDTH-1:FIELD_W]};
`else
    assign irq_cond_c = |(isr & ier);
    assign unused_ok  = &{1'b0, PWDATA[DATA_WIDTH-1:FIELD_W], req_wdata[FIELD_W-1:SRC_W]};
`endif

    // Register file; a source pulse wins over a simultaneous W1C of its bit.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            ier     <= '0;
            isr     <= '0;
            TMR_IRQ <= 1'b0;
        end else begin
            if (wr_ier_c) begin
                ier <= req_wdata[SRC_W-1:0];
            end
            isr     <= (isr & ~isr_clr_c) | evt_c;
            TMR_IRQ <= irq_cond_c;
        end
    end

`ifdef TMR_IRQ_COALESCE_EN
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            ithr <= FIELD_W'(ITHR_RST);
        end else if (wr_ithr_c) begin
            ithr <= req_wdata;
        end
    end
`endif

    irq_event_counter u_evt_cnt (
        .clk       (PCLK),
        .rst_n     (PRESET_n),
        .ovf_evt   (evt_en_c[OVF_BIT]),
        .udf_evt   (evt_en_c[UDF_BIT]),
        .clr       (icnt_clr_c),
`ifdef TMR_IRQ_COALESCE_EN
        .thr       (ithr),
        .thr_met_c (thr_met_c),
`endif
        .icnt      (icnt)
    );

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// Self-checking bench for tmr_irq_ctrl: register-level model plus directed APB/pulse vectors.
module tb_tmr_irq_ctrl;

    logic       PCLK;
    logic       PRESET_n;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       Set_OVF_pulse;
    logic       Set_UDF_pulse;
    logic       TMR_IRQ;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model state and the write the bench expects to commit this cycle.
    int   m_ier, m_isr, m_icnt, m_ithr, m_irq;
    bit   m_commit;
    int   m_addr, m_wdata;
    logic [7:0] rd;

    tmr_irq_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .PCLK          (PCLK),
        .PRESET_n      (PRESET_n),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .Set_OVF_pulse (Set_OVF_pulse),
        .Set_UDF_pulse (Set_UDF_pulse),
        .TMR_IRQ       (TMR_IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit exp_err(input bit wr, input int addr);
        case (addr)
            'h10, 'h11: return 1'b0;
            'h12:       return wr;
`ifdef TMR_IRQ_COALESCE_EN
            'h13:       return 1'b0;
`endif
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int model_read(input int addr);
        case (addr)
            'h10:    return m_ier;
            'h11:    return m_isr;
            'h12:    return m_icnt;
            'h13:    return m_ithr;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_cond();
        bit pend;
        int thr;
        pend = (m_isr & m_ier) != 0;
        thr  = (m_ithr == 0) ? 1 : m_ithr;
`ifdef TMR_IRQ_COALESCE_EN
        return pend && (m_icnt >= thr);
`else
        return pend && (thr > 0);
`endif
    endfunction

    // Register-level model, stepped on the same edges the design uses.
    always @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            m_ier  <= 0;
            m_isr  <= 0;
            m_icnt <= 0;
            m_ithr <= 1;
            m_irq  <= 0;
        end else begin
            int clr, inc, evt;
            clr = (m_commit && m_addr == 'h11) ? (m_wdata & 3) : 0;
            evt = (Set_UDF_pulse ? 2 : 0) + (Set_OVF_pulse ? 1 : 0);
            inc = ((evt & m_ier & 1) != 0 ? 1 : 0) + ((evt & m_ier & 2) != 0 ? 1 : 0);
            m_isr  <= (m_isr & ~clr) | evt;
            m_icnt <= min15(((clr != 0) ? 0 : m_icnt) + inc);
            if (m_commit && m_addr == 'h10) m_ier  <= m_wdata & 3;
            if (m_commit && m_addr == 'h13) m_ithr <= m_wdata & 15;
            m_irq  <= model_cond() ? 1 : 0;
        end
    end

    // Interrupt output compared against the model on every falling edge.
    always @(negedge PCLK) begin
        if (chk_en) check("tmr_irq_vs_model", {31'd0, TMR_IRQ}, m_irq);
    end

    // One APB transfer; optional source pulses land in the commit cycle.
    task automatic apb(input bit wr, input int addr, input int data,
                       input bit p_ovf, input bit p_udf, output logic [7:0] rdata);
        bit   err;
        int   exp_rd;
        err = exp_err(wr, addr);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = wr; PADDR = 8'(addr); PWDATA = 8'(data); PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("pready_wait", {31'd0, PREADY}, 0);
        exp_rd = (wr || err) ? 0 : model_read(addr);
        @(negedge PCLK);
        check("pready_ready", {31'd0, PREADY}, 1);
        check("pslverr", {31'd0, PSLVERR}, {31'd0, err});
        if (!wr || err) check("prdata", {24'd0, PRDATA}, exp_rd);
        rdata = PRDATA;
        if (wr && !err) begin
            m_commit = 1'b1; m_addr = addr; m_wdata = data;
        end
        Set_OVF_pulse = p_ovf; Set_UDF_pulse = p_udf;
        @(negedge PCLK);
        m_commit = 1'b0; Set_OVF_pulse = 1'b0; Set_UDF_pulse = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        check("pready_idle", {31'd0, PREADY}, 0);
    endtask

    task automatic pulse(input bit ovf, input bit udf);
        @(negedge PCLK);
        Set_OVF_pulse = ovf; Set_UDF_pulse = udf;
        @(negedge PCLK);
        Set_OVF_pulse = 1'b0; Set_UDF_pulse = 1'b0;
    endtask

    initial begin
        PRESET_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; Set_OVF_pulse = 1'b0; Set_UDF_pulse = 1'b0;
        m_commit = 1'b0; m_addr = 0; m_wdata = 0;
        #2;
        check("rst_pready",  {31'd0, PREADY}, 0);
        check("rst_pslverr", {31'd0, PSLVERR}, 0);
        check("rst_prdata",  {24'd0, PRDATA}, 0);
        check("rst_irq",     {31'd0, TMR_IRQ}, 0);
        @(negedge PCLK); @(negedge PCLK);
        PRESET_n = 1'b1;
        chk_en = 1'b1;

        // Reset values.
        apb(0, 'h10, 0, 0, 0, rd); check("rst_ier", rd, 0);
        apb(0, 'h11, 0, 0, 0, rd); check("rst_isr", rd, 0);
        apb(0, 'h12, 0, 0, 0, rd); check("rst_icnt", rd, 0);
`ifdef TMR_IRQ_COALESCE_EN
        apb(0, 'h13, 0, 0, 0, rd); check("rst_ithr", rd, 1);
`else
        apb(0, 'h13, 0, 0, 0, rd); check("ithr_absent_rd", rd, 0);
`endif

        // Enable both, one overflow pulse.
        apb(1, 'h10, 'h03, 0, 0, rd);
        pulse(1, 0);
        check("irq_not_yet", {31'd0, TMR_IRQ}, 0);
        @(negedge PCLK);
        check("irq_after_ovf", {31'd0, TMR_IRQ}, 1);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_ovf", rd, 'h01);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_ovf", rd, 1);
        check("model_icnt_pin", m_icnt, 1);
        apb(1, 'h11, 'h01, 0, 0, rd);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_cleared", rd, 0);

        // Only UDF enabled, both pulses together.
        apb(1, 'h10, 'h02, 0, 0, rd);
        pulse(1, 1);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_both", rd, 'h03);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_udf_only", rd, 1);
        apb(1, 'h11, 'h03, 0, 0, rd);
        @(negedge PCLK);
        check("irq_cleared", {31'd0, TMR_IRQ}, 0);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_w1c", rd, 0);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_w1c", rd, 0);

        // Saturation, then pulse colliding with W1C.
        for (int i = 0; i < 17; i++) pulse(0, 1);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_sat", rd, 15);
        apb(1, 'h11, 'h02, 0, 1, rd);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_set_wins", rd, 'h02);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_set_wins", rd, 1);

        // IER cleared: irq drops, pending kept.
        apb(1, 'h10, 'h00, 0, 0, rd);
        @(negedge PCLK);
        check("irq_ier0", {31'd0, TMR_IRQ}, 0);
        apb(0, 'h11, 0, 0, 0, rd); check("isr_retained", rd, 'h02);

        // Error responses.
        apb(0, 'h20, 0, 0, 0, rd); check("unmapped_rd", rd, 0);
        apb(1, 'h12, 'h05, 0, 0, rd);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_ro", rd, 1);

        // Abort: PSEL dropped in WAIT.
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 8'h03; PENABLE = 1'b0;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
        check("abort_pready0", {31'd0, PREADY}, 0);
        @(negedge PCLK); check("abort_pready1", {31'd0, PREADY}, 0);
        apb(0, 'h10, 0, 0, 0, rd); check("abort_no_commit", rd, 0);

        // Both sources enabled together: +2.
        apb(1, 'h10, 'h03, 0, 0, rd);
        apb(1, 'h11, 'h03, 0, 0, rd);
        pulse(1, 1);
        apb(0, 'h12, 0, 0, 0, rd); check("icnt_plus2", rd, 2);

        // Coalescing threshold.
        apb(1, 'h11, 'h03, 0, 0, rd);
        apb(1, 'h13, 'h03, 0, 0, rd);
        apb(1, 'h10, 'h01, 0, 0, rd);
        pulse(1, 0); @(negedge PCLK);
`ifdef TMR_IRQ_COALESCE_EN
        check("coal_p1", {31'd0, TMR_IRQ}, 0);
        pulse(1, 0); @(negedge PCLK); check("coal_p2", {31'd0, TMR_IRQ}, 0);
        pulse(1, 0); @(negedge PCLK); check("coal_p3", {31'd0, TMR_IRQ}, 1);
`else
        check("base_p1", {31'd0, TMR_IRQ}, 1);
        pulse(1, 0); pulse(1, 0); @(negedge PCLK);
        check("base_p3", {31'd0, TMR_IRQ}, 1);
`endif

        // Reset asserted in WAIT of an IER write.
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 8'h03; PENABLE = 1'b0;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK);
        check("pre_rst_irq", {31'd0, TMR_IRQ}, 1);
        #2 PRESET_n = 1'b0;
        #1;
        check("midrst_pready", {31'd0, PREADY}, 0);
        check("midrst_irq", {31'd0, TMR_IRQ}, 0);
        @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESET_n = 1'b1;
        apb(0, 'h10, 0, 0, 0, rd); check("post_rst_ier", rd, 0);
        apb(0, 'h11, 0, 0, 0, rd); check("post_rst_isr", rd, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
